// File: rtl/param_modn_counter.sv
// param_modn_counter
// Synchronous modulo-N up/down counter with parallel load, enable, and
// one-shot or free-run operation. It reports terminal count (tc), a wrap
// pulse, a done level and a busy level.
// q, wrap, done and busy are registered. tc is decoded combinationally from
// the registered state and the live direction input.

module param_modn_counter #(
   parameter int              WIDTH      = 4,
   parameter longint unsigned MODULUS    = 16,
   parameter longint unsigned RESET_VAL  = 0,
   parameter bit              AUTO_START = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             one_shot,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             done,
   output logic             busy
);

   // Modulus is held WIDTH+1 bits wide so that MODULUS == 2**WIDTH fits.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam state_t RST_STATE = AUTO_START ? RUN : IDLE;

   state_t state;

   // The terminal value is the last value before a wrap in the current direction.
   function automatic logic [WIDTH-1:0] terminal_val(input logic dir_up);
      return dir_up ? MAX_VAL : '0;
   endfunction

   // The start value is the first value of a fresh count in the current direction.
   function automatic logic [WIDTH-1:0] start_val(input logic dir_up);
      return dir_up ? '0 : MAX_VAL;
   endfunction

   // Load values outside the count range saturate to the largest legal value.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      logic [WIDTH:0] ext;
      ext = {1'b0, v};
      if (ext >= MOD_EXT) begin
         return MAX_VAL;
      end
      return v;
   endfunction

   // Compute one step in WIDTH+1 bits.
   // An out-of-range result folds back into 0..MODULUS-1, so q is never
   // loaded with a value at or above MODULUS, even in the terminal cases.
   // Those terminal cases are normally handled by the FSM before this
   // function is reached.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] cur,
                                             input logic             dir_up);
      logic [WIDTH:0] sum;
      if (dir_up) begin
         sum = {1'b0, cur} + (WIDTH+1)'(1);
         if (sum >= MOD_EXT) begin
            sum = '0;
         end
      end else begin
         sum = {1'b0, cur} - (WIDTH+1)'(1);
         if (sum[WIDTH]) begin
            sum = {1'b0, MAX_VAL};
         end
      end
      return sum[WIDTH-1:0];
   endfunction

   // Terminal count is only meaningful while the counter is running.
   assign tc = (state == RUN) && (q == terminal_val(up));

   // Single FSM: state, count value and all registered status outputs.
   // Priority is reset, then load, then start, then count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RST_STATE;
         q     <= RST_Q;
         wrap  <= 1'b0;
         done  <= 1'b0;
         busy  <= AUTO_START;
      end else begin
         wrap <= 1'b0;
         if (load) begin
            q <= clamp_load(load_val);
            if (state == DONE) begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         end else if (start) begin
            state <= RUN;
            q     <= start_val(up);
            done  <= 1'b0;
            busy  <= 1'b1;
         end else begin
            case (state)
               RUN: begin
                  if (en) begin
                     if (q == terminal_val(up)) begin
                        if (one_shot) begin
                           state <= DONE;
                           done  <= 1'b1;
                           busy  <= 1'b0;
                        end else begin
                           q    <= start_val(up);
                           wrap <= 1'b1;
                        end
                     end else begin
                        q <= step(q, up);
                     end
                  end
               end
               DONE: begin
                  // Hold the terminal value until a start or a load arrives.
               end
               default: begin
                  // IDLE holds q and ignores en.
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_param_modn_counter.sv
// tb_param_modn_counter
// The bench drives three counters from the same input bus:
//   - a mod-10 counter that starts running out of reset;
//   - a mod-16 counter that starts running out of reset;
//   - a mod-10 counter that resets to 5 and starts in IDLE.
// Expected outputs are pushed to a queue when each vector is driven. Each
// entry is popped and compared one cycle later, after the clock edge.

module tb_param_modn_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
   logic       one_shot = 1'b0, start = 1'b0;
   logic [3:0] load_val = '0;

   logic [3:0] q10, q16, qid;
   logic       tc10, wr10, dn10, bz10;
   logic       tc16, wr16, dn16, bz16;
   logic       tcid, wrid, dnid, bzid;

   always #5 clk = ~clk;

   param_modn_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .AUTO_START(1'b1)) dut10 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .one_shot(one_shot), .start(start), .q(q10), .tc(tc10), .wrap(wr10),
      .done(dn10), .busy(bz10));

   param_modn_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0), .AUTO_START(1'b1)) dut16 (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .one_shot(one_shot), .start(start), .q(q16), .tc(tc16), .wrap(wr16),
      .done(dn16), .busy(bz16));

   param_modn_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(5), .AUTO_START(1'b0)) dut_idle (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .one_shot(one_shot), .start(start), .q(qid), .tc(tcid), .wrap(wrid),
      .done(dnid), .busy(bzid));

   typedef struct {
      bit         rst, en, up, ld, os, st;
      logic [3:0] lv;
      logic [3:0] q;
      bit         tc, wr, dn, bz;
   } vec_t;

   typedef struct {
      logic [7:0] exp;
      int         sel;
      string      tag;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   step_no = 0;

   function automatic vec_t mk(bit rst, bit en_i, bit up_i, bit ld, logic [3:0] lv,
                               bit os, bit st, logic [3:0] eq, bit etc, bit ewr,
                               bit edn, bit ebz);
      vec_t v;
      v.rst = rst; v.en = en_i; v.up = up_i; v.ld = ld; v.lv = lv;
      v.os = os; v.st = st;
      v.q = eq; v.tc = etc; v.wr = ewr; v.dn = edn; v.bz = ebz;
      return v;
   endfunction

   // Drive one vector, queue its expectation, then check the selected DUT after the edge.
   task automatic apply(input vec_t v, input int sel, input string tag);
      sb_t e, g;
      logic [7:0] act;
      @(negedge clk);
      reset = v.rst; en = v.en; up = v.up; load = v.ld; load_val = v.lv;
      one_shot = v.os; start = v.st;
      e.exp = {v.q, v.tc, v.wr, v.dn, v.bz};
      e.sel = sel;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      case (g.sel)
         1:       act = {q16, tc16, wr16, dn16, bz16};
         2:       act = {qid, tcid, wrid, dnid, bzid};
         default: act = {q10, tc10, wr10, dn10, bz10};
      endcase
      step_no++;
      n_cmp++;
      if (act !== g.exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got q=%0d tc=%b wrap=%b done=%b busy=%b, expected q=%0d tc=%b wrap=%b done=%b busy=%b",
                  g.tag, step_no, act[7:4], act[3], act[2], act[1], act[0],
                  g.exp[7:4], g.exp[3], g.exp[2], g.exp[1], g.exp[0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Table for the mod-10 counter. The fields are:
      //   rst en up ld lv os st | q tc wr dn bz
      // Up count after reset, including a wrap from 9 to 0.
      vecs.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0,1));
      vecs.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0,1));
      for (int i = 1; i <= 9; i++)
         vecs.push_back(mk(0,1,1,0,0,0,0, 4'(i), (i == 9),0,0,1));
      vecs.push_back(mk(0,1,1,0,0,0,0, 0,0,1,0,1));
      vecs.push_back(mk(0,1,1,0,0,0,0, 1,0,0,0,1));
      // Load 3, then count down through a wrap from 0 to 9.
      vecs.push_back(mk(0,0,0,1,3,0,0, 3,0,0,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0, 2,0,0,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0, 1,0,0,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0, 0,1,0,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0, 9,0,1,0,1));
      vecs.push_back(mk(0,1,0,0,0,0,0, 8,0,0,0,1));
      // A load of 12 clamps to 9. A load together with start gives load priority.
      vecs.push_back(mk(0,0,1,1,12,0,0, 9,1,0,0,1));
      vecs.push_back(mk(0,0,1,1,4,0,1, 4,0,0,0,1));
      // Enable gating from 6, a direction change while idle, then reset with load.
      vecs.push_back(mk(0,0,1,1,6,0,0, 6,0,0,0,1));
      vecs.push_back(mk(0,1,1,0,0,0,0, 7,0,0,0,1));
      vecs.push_back(mk(0,0,1,0,0,0,0, 7,0,0,0,1));
      vecs.push_back(mk(0,0,1,0,0,0,0, 7,0,0,0,1));
      vecs.push_back(mk(0,1,1,0,0,0,0, 8,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,0, 8,0,0,0,1));
      vecs.push_back(mk(1,0,1,1,5,0,1, 0,0,0,0,1));

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i], 0, "table");

      // One-shot run: count to 9, enter DONE, hold there with en high, then restart.
      apply(mk(0,0,1,0,0,1,1, 0,0,0,0,1), 0, "oneshot_start");
      for (int i = 1; i <= 9; i++)
         apply(mk(0,1,1,0,0,1,0, 4'(i), (i == 9),0,0,1), 0, "oneshot_count");
      apply(mk(0,1,1,0,0,1,0, 9,0,0,1,0), 0, "oneshot_done");
      for (int i = 0; i < 5; i++)
         apply(mk(0,1,1,0,0,1,0, 9,0,0,1,0), 0, "done_hold");
      apply(mk(0,0,1,0,0,1,1, 0,0,0,0,1), 0, "done_restart");
      // Reach DONE again, load to IDLE, check that IDLE holds, then start downward.
      for (int i = 1; i <= 9; i++)
         apply(mk(0,1,1,0,0,1,0, 4'(i), (i == 9),0,0,1), 0, "oneshot_count2");
      apply(mk(0,1,1,0,0,1,0, 9,0,0,1,0), 0, "oneshot_done2");
      apply(mk(0,0,1,1,2,0,0, 2,0,0,0,0), 0, "done_load_idle");
      apply(mk(0,1,1,0,0,0,0, 2,0,0,0,0), 0, "idle_hold");
      apply(mk(0,0,0,0,0,0,1, 9,0,0,0,1), 0, "idle_start_down");
      apply(mk(0,1,0,0,0,0,0, 8,0,0,0,1), 0, "down_step");
      apply(mk(0,1,1,0,0,0,1, 0,0,0,0,1), 0, "run_restart");

      // Full-range modulus: natural wrap in both directions.
      apply(mk(1,0,1,0,0,0,0, 0,0,0,0,1), 1, "m16_reset");
      apply(mk(0,0,1,1,15,0,0, 15,1,0,0,1), 1, "m16_load15");
      apply(mk(0,1,1,0,0,0,0, 0,0,1,0,1), 1, "m16_wrap_up");
      apply(mk(0,1,0,0,0,0,0, 15,0,1,0,1), 1, "m16_wrap_down");
      apply(mk(0,1,0,0,0,0,0, 14,0,0,0,1), 1, "m16_down");

      // Non-zero reset value with the counter starting in IDLE.
      apply(mk(1,0,1,0,0,0,0, 5,0,0,0,0), 2, "idle_reset");
      apply(mk(0,1,1,0,0,0,0, 5,0,0,0,0), 2, "idle_en_ignored");
      apply(mk(0,0,1,0,0,0,1, 0,0,0,0,1), 2, "idle_start");
      apply(mk(0,1,1,0,0,0,0, 1,0,0,0,1), 2, "idle_run_step");

      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
